// File: rtl/cardinal_nic_fifo.sv
// Network interface buffer: an output FIFO from processor to router and an input
// FIFO from router to processor, with memory-mapped data/status registers.
module cardinal_nic_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C = AW'(DEPTH - 1);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_C) ? {AW{1'b0}} : p + AW'(1'b1);
  endfunction

  // Status word layout: bit 0 flag, bit 1 sticky drop, then occupancy.
  function automatic logic [DATA_W-1:0] status_word(input logic flag, input logic drop,
                                                    input logic [CW-1:0] cnt);
    logic [DATA_W-1:0] w;
    w = {DATA_W{1'b0}};
    w[0] = flag;
    w[1] = drop;
    w[CW+1:2] = cnt;
    return w;
  endfunction

  logic [DATA_W-1:0] out_mem_r [DEPTH];
  logic [DATA_W-1:0] in_mem_r  [DEPTH];
  logic [AW-1:0]     out_wr_ptr_r, out_rd_ptr_r, in_wr_ptr_r, in_rd_ptr_r;
  logic [CW-1:0]     out_count_r, in_count_r;
  logic [CW-1:0]     out_count_nxt_s, in_count_nxt_s;
  logic              out_drop_r, in_drop_r, in_ready_r;
  logic [DATA_W-1:0] d_out_r, rd_data_s, out_head_s, in_head_s;

  logic proc_rd_s, proc_wr_s, out_empty_s, out_full_s, in_empty_s, in_full_s;
  logic out_push_s, out_pop_s, out_drop_set_s, in_push_s, in_pop_s, in_drop_set_s;
  logic in_stat_rd_s, out_stat_rd_s;

  assign proc_rd_s      = nicEn & ~nicWrEn;
  assign proc_wr_s      = nicEn & nicWrEn;
  assign out_empty_s    = (out_count_r == {CW{1'b0}});
  assign out_full_s     = (out_count_r == FULL_C);
  assign in_empty_s     = (in_count_r == {CW{1'b0}});
  assign in_full_s      = (in_count_r == FULL_C);
  assign out_head_s     = out_mem_r[out_rd_ptr_r];
  assign in_head_s      = in_mem_r[in_rd_ptr_r];

  assign out_push_s     = proc_wr_s & (addr == 2'b10) & ~out_full_s;
  assign out_drop_set_s = proc_wr_s & (addr == 2'b10) & out_full_s;
  // A flit only leaves when its VC bit matches the router's current phase.
  assign out_pop_s      = ~out_empty_s & net_ro & (out_head_s[DATA_W-1] == net_polarity);
  assign in_push_s      = net_si & in_ready_r;
  assign in_drop_set_s  = net_si & ~in_ready_r;
  assign in_pop_s       = proc_rd_s & (addr == 2'b00) & ~in_empty_s;
  assign in_stat_rd_s   = proc_rd_s & (addr == 2'b01);
  assign out_stat_rd_s  = proc_rd_s & (addr == 2'b11);

  assign net_so = out_pop_s;
  assign net_do = out_empty_s ? {DATA_W{1'b0}} : out_head_s;
  assign net_ri = in_ready_r;
  assign d_out  = d_out_r;

  // Processor read data selected by register address.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    case (addr)
      2'b00:   rd_data_s = in_empty_s ? {DATA_W{1'b0}} : in_head_s;
      2'b01:   rd_data_s = status_word(~in_empty_s, in_drop_r, in_count_r);
      2'b10:   rd_data_s = {DATA_W{1'b0}};
      2'b11:   rd_data_s = status_word(out_full_s, out_drop_r, out_count_r);
      default: rd_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Next occupancy of both FIFOs; simultaneous push and pop cancel out.
  always_comb begin
    out_count_nxt_s = out_count_r;
    in_count_nxt_s  = in_count_r;
    if (out_push_s && !out_pop_s) begin
      out_count_nxt_s = out_count_r + CW'(1'b1);
    end else if (out_pop_s && !out_push_s) begin
      out_count_nxt_s = out_count_r - CW'(1'b1);
    end else begin
      out_count_nxt_s = out_count_r;
    end
    if (in_push_s && !in_pop_s) begin
      in_count_nxt_s = in_count_r + CW'(1'b1);
    end else if (in_pop_s && !in_push_s) begin
      in_count_nxt_s = in_count_r - CW'(1'b1);
    end else begin
      in_count_nxt_s = in_count_r;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every use.
  always_ff @(posedge clk) begin
    if (out_push_s) out_mem_r[out_wr_ptr_r] <= d_in;
    if (in_push_s)  in_mem_r[in_wr_ptr_r]   <= net_di;
  end

  // Pointers, counters, sticky drop flags, input ready and read data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr_ptr_r <= {AW{1'b0}};
      out_rd_ptr_r <= {AW{1'b0}};
      in_wr_ptr_r  <= {AW{1'b0}};
      in_rd_ptr_r  <= {AW{1'b0}};
      out_count_r  <= {CW{1'b0}};
      in_count_r   <= {CW{1'b0}};
      out_drop_r   <= 1'b0;
      in_drop_r    <= 1'b0;
      in_ready_r   <= 1'b0;
      d_out_r      <= {DATA_W{1'b0}};
    end else begin
      if (out_push_s) out_wr_ptr_r <= ptr_inc(out_wr_ptr_r);
      if (out_pop_s)  out_rd_ptr_r <= ptr_inc(out_rd_ptr_r);
      if (in_push_s)  in_wr_ptr_r  <= ptr_inc(in_wr_ptr_r);
      if (in_pop_s)   in_rd_ptr_r  <= ptr_inc(in_rd_ptr_r);
      out_count_r <= out_count_nxt_s;
      in_count_r  <= in_count_nxt_s;
      // A new drop wins over a clearing status read on the same edge.
      out_drop_r  <= out_drop_set_s | (out_drop_r & ~out_stat_rd_s);
      in_drop_r   <= in_drop_set_s | (in_drop_r & ~in_stat_rd_s);
      in_ready_r  <= (in_count_nxt_s != FULL_C);
      if (proc_rd_s) d_out_r <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Self-checking bench for cardinal_nic_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_cardinal_nic_fifo;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in, d_out, net_do, net_di;
  logic              nicEn, nicWrEn, net_so, net_ro, net_polarity, net_si, net_ri;
  int                checks = 0;
  int                errors = 0;

  cardinal_nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = 64'h0;
    net_ro = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = 64'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic cpu_write(input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = d;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    tick();
    nicEn = 1'b0;
  endtask

  task automatic net_push(input logic [63:0] d);
    net_si = 1'b1; net_di = d;
    tick();
    net_si = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Expected status register value: occupancy*4 + drop*2 + flag.
  function automatic logic [63:0] stat(input int cnt, input bit drop, input bit flag);
    return 64'(cnt * 4 + (drop ? 2 : 0) + (flag ? 1 : 0));
  endfunction

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL reset_ri actual=%b expected=0", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so actual=%b expected=0", net_so); end
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_dout actual=%h expected=0", d_out); end
    checks++; if (net_do !== 64'h0) begin errors++; $display("FAIL reset_do actual=%h expected=0", net_do); end
    reset = 1'b1;
    tick();
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL idle_ri actual=%b expected=1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL idle_so actual=%b expected=0", net_so); end
    cpu_read(2'b01);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL idle_stat_in actual=%h expected=0", d_out); end
    cpu_read(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL idle_stat_out actual=%h expected=0", d_out); end
  endtask

  task automatic test_out_fill();
    logic [63:0] f [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      f[i] = rnd64();
      cpu_write(f[i]);
    end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL outfill_so actual=%b expected=0", net_so); end
    cpu_read(2'b11);
    checks++; if (d_out !== 64'h13) begin errors++; $display("FAIL outfill_stat1 actual=%h expected=13", d_out); end
    cpu_read(2'b11);
    checks++; if (d_out !== 64'h11) begin errors++; $display("FAIL outfill_stat2 actual=%h expected=11", d_out); end
    net_ro = 1'b1;
    for (int i = 0; i < 4; i++) begin
      net_polarity = f[i][63];
      #1;
      checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL drain_so[%0d] actual=%b expected=1", i, net_so); end
      checks++; if (net_do !== f[i]) begin errors++; $display("FAIL drain_do[%0d] actual=%h expected=%h", i, net_do, f[i]); end
      tick();
    end
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL drained_so actual=%b expected=0", net_so); end
    checks++; if (net_do !== 64'h0) begin errors++; $display("FAIL drained_do actual=%h expected=0", net_do); end
    net_ro = 1'b0;
    cpu_read(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL drained_stat actual=%h expected=0", d_out); end
  endtask

  task automatic test_polarity();
    logic [63:0] f [4];
    int          sent;
    logic [63:0] exp_stat;
    bit          exp_so;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      f[i] = rnd64();
      f[i][63] = 1'b1;
      cpu_write(f[i]);
    end
    sent = 0;
    net_ro = 1'b1;
    for (int c = 0; c < 8; c++) begin
      net_polarity = c[0];
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b11;
      #1;
      exp_so = (c[0] == 1'b1) && (sent < 4);
      checks++; if (net_so !== exp_so) begin errors++; $display("FAIL pol_so[%0d] actual=%b expected=%b", c, net_so, exp_so); end
      if (exp_so) begin
        checks++; if (net_do !== f[sent]) begin errors++; $display("FAIL pol_do[%0d] actual=%h expected=%h", c, net_do, f[sent]); end
      end
      exp_stat = stat(4 - sent, 1'b0, (4 - sent) == 4);
      tick();
      checks++; if (d_out !== exp_stat) begin errors++; $display("FAIL pol_count[%0d] actual=%h expected=%h", c, d_out, exp_stat); end
      if (exp_so) sent++;
    end
    idle();
    cpu_read(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL pol_final actual=%h expected=0", d_out); end
  endtask

  task automatic test_in_fill();
    logic [63:0] f [5];
    do_reset();
    for (int i = 0; i < 5; i++) f[i] = rnd64();
    for (int i = 0; i < 4; i++) begin
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL infill_ri[%0d] actual=%b expected=1", i, net_ri); end
      net_push(f[i]);
    end
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL infill_full_ri actual=%b expected=0", net_ri); end
    net_push(f[4]);
    cpu_read(2'b01);
    checks++; if (d_out !== 64'h13) begin errors++; $display("FAIL infill_stat actual=%h expected=13", d_out); end
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'b00);
      checks++; if (d_out !== f[i]) begin errors++; $display("FAIL infill_pop[%0d] actual=%h expected=%h", i, d_out, f[i]); end
    end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL infill_ri_after actual=%b expected=1", net_ri); end
    cpu_read(2'b00);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL infill_empty_pop actual=%h expected=0", d_out); end
    cpu_read(2'b01);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL infill_stat_clr actual=%h expected=0", d_out); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q [$];
    logic [63:0] nf, exp;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      nf = rnd64();
      q.push_back(nf);
      net_push(nf);
    end
    for (int i = 0; i < 6; i++) begin
      nf = rnd64();
      net_si = 1'b1; net_di = nf;
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
      #1;
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL b2b_ri[%0d] actual=%b expected=1", i, net_ri); end
      exp = q.pop_front();
      q.push_back(nf);
      tick();
      checks++; if (d_out !== exp) begin errors++; $display("FAIL b2b_pop[%0d] actual=%h expected=%h", i, d_out, exp); end
    end
    idle();
    cpu_read(2'b01);
    checks++; if (d_out !== 64'h09) begin errors++; $display("FAIL b2b_stat actual=%h expected=09", d_out); end
    for (int i = 0; i < 2; i++) begin
      exp = q.pop_front();
      cpu_read(2'b00);
      checks++; if (d_out !== exp) begin errors++; $display("FAIL b2b_drain[%0d] actual=%h expected=%h", i, d_out, exp); end
    end
  endtask

  task automatic test_random();
    logic [63:0] in_q [$];
    logic [63:0] out_q [$];
    logic [63:0] exp_dout, exp_do, tmp;
    bit in_drop, out_drop, exp_so, exp_ri, in_full, out_full, rd, wr, in_clr, out_clr, in_set, out_set;
    int in_cnt, out_cnt;
    do_reset();
    in_drop = 0; out_drop = 0; exp_dout = 64'h0;
    for (int n = 0; n < 400; n++) begin
      nicEn = ($urandom() % 4) != 0;
      nicWrEn = $urandom() % 2;
      addr = (nicWrEn && ($urandom() % 3 != 0)) ? 2'b10 : 2'($urandom() % 4);
      d_in = rnd64();
      net_ro = ($urandom() % 3) != 0;
      net_polarity = $urandom() % 2;
      net_si = ($urandom() % 3) == 0;
      net_di = rnd64();
      #1;
      in_cnt = in_q.size(); out_cnt = out_q.size();
      in_full = (in_cnt == DEPTH); out_full = (out_cnt == DEPTH);
      exp_so = (out_cnt > 0) && net_ro && (out_q[0][63] == net_polarity);
      exp_ri = !in_full;
      exp_do = (out_cnt > 0) ? out_q[0] : 64'h0;
      checks++; if (net_so !== exp_so) begin errors++; $display("FAIL rnd_so[%0d] actual=%b expected=%b", n, net_so, exp_so); end
      checks++; if (net_ri !== exp_ri) begin errors++; $display("FAIL rnd_ri[%0d] actual=%b expected=%b", n, net_ri, exp_ri); end
      checks++; if (net_do !== exp_do) begin errors++; $display("FAIL rnd_do[%0d] actual=%h expected=%h", n, net_do, exp_do); end
      rd = nicEn && !nicWrEn; wr = nicEn && nicWrEn;
      in_clr = 0; out_clr = 0; in_set = 0; out_set = 0;
      if (rd) begin
        case (addr)
          2'b00: if (in_cnt > 0) exp_dout = in_q.pop_front(); else exp_dout = 64'h0;
          2'b01: begin exp_dout = stat(in_cnt, in_drop, in_cnt > 0); in_clr = 1; end
          2'b10: exp_dout = 64'h0;
          default: begin exp_dout = stat(out_cnt, out_drop, out_full); out_clr = 1; end
        endcase
      end
      if (exp_so) tmp = out_q.pop_front();
      if (wr && addr == 2'b10) begin
        if (!out_full) out_q.push_back(d_in); else out_set = 1;
      end
      if (net_si) begin
        if (!in_full) in_q.push_back(net_di); else in_set = 1;
      end
      in_drop = in_set || (in_drop && !in_clr);
      out_drop = out_set || (out_drop && !out_clr);
      tick();
      checks++; if (d_out !== exp_dout) begin errors++; $display("FAIL rnd_dout[%0d] actual=%h expected=%h", n, d_out, exp_dout); end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    logic [63:0] f;
    do_reset();
    f = rnd64();
    f[63] = 1'b0;
    cpu_write(f);
    for (int i = 0; i < 2; i++) cpu_write(rnd64());
    for (int i = 0; i < 3; i++) net_push(rnd64());
    cpu_read(2'b01);
    checks++; if (d_out !== 64'h0D) begin errors++; $display("FAIL mid_stat actual=%h expected=0d", d_out); end
    net_ro = 1'b1; net_polarity = 1'b0;
    #1;
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL mid_so_pre actual=%b expected=1", net_so); end
    reset = 1'b0;
    #1;
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mid_so actual=%b expected=0", net_so); end
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL mid_ri actual=%b expected=0", net_ri); end
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mid_dout actual=%h expected=0", d_out); end
    checks++; if (net_do !== 64'h0) begin errors++; $display("FAIL mid_do actual=%h expected=0", net_do); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL mid_ri_after actual=%b expected=1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mid_so_after actual=%b expected=0", net_so); end
    cpu_read(2'b01);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mid_stat_in actual=%h expected=0", d_out); end
    cpu_read(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL mid_stat_out actual=%h expected=0", d_out); end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_out_fill();
    test_polarity();
    test_in_fill();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cardinal_nic_fifo.md
CARDINAL_NIC_FIFO -- requirements
Module: cardinal_nic_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64: flit width on the processor and network sides.
REQ-002 SHALL have parameter DEPTH, default 4: entries per channel FIFO; power of two, >=2; DATA_W >= clog2(DEPTH)+3.
REQ-003 SHALL have ports, with CW = clog2(DEPTH)+1, "VC bit" = most-significant data bit, and "bit 0" = least-significant bit:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  register select: 00 input data, 01 input status, 10 output data, 11 output status.
- d_in  in  DATA_W  processor write data.
- d_out  out  DATA_W  processor read data, registered.
- nicEn  in  1  processor access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send strobe to router.
- net_ro  in  1  router ready to accept.
- net_do  out  DATA_W  flit to router.
- net_polarity  in  1  router VC phase.
- net_si  in  1  router send strobe into NIC.
- net_ri  out  1  NIC ready to accept.
- net_di  in  DATA_W  flit from router.

Function
REQ-004 SHALL contain an output FIFO (processor to network) and an input FIFO (network to processor), each DEPTH entries, with CW-bit occupancy counters and wrapping read/write pointers.
REQ-005 SHALL push d_in into the output FIFO on a clock edge with nicEn=1, nicWrEn=1, addr=10 if it was not full at the start of that cycle; otherwise drop the write and set sticky out_drop.
REQ-006 SHALL ignore processor writes to addr 00, 01 and 11.
REQ-007 SHALL assert net_so combinationally when the output FIFO is non-empty, net_ro=1, and the head VC bit equals net_polarity; net_do SHALL equal the head entry at all times, or 0 when the FIFO is empty.
REQ-008 SHALL pop the output FIFO on each edge where net_so=1; one flit per cycle; back-to-back sends allowed.
REQ-009 SHALL drive net_ri=1 iff the input FIFO was not full at the start of the cycle; a processor pop in the same cycle SHALL NOT raise net_ri (no fall-through).
REQ-010 SHALL push net_di on an edge with net_si=1 and net_ri=1; net_si=1 with net_ri=0 SHALL drop the flit and set sticky in_drop.
REQ-011 SHALL, on an edge with nicEn=1, nicWrEn=0, addr=00, load d_out with the input FIFO head and pop it; if empty, load d_out=0 and make no pointer change.
REQ-012 SHALL, on a read of addr 01, load d_out with: bit 0 = input non-empty, bit 1 = in_drop, bits [CW+1:2] = input count, other bits 0; then clear in_drop.
REQ-013 SHALL, on a read of addr 11, load d_out with: bit 0 = output full, bit 1 = out_drop, bits [CW+1:2] = output count, other bits 0; then clear out_drop.
REQ-014 SHALL, on a read of addr 10, load d_out=0.
REQ-015 SHALL hold d_out when nicEn=0; read data is visible one cycle after the read edge.
REQ-016 SHALL let a simultaneous push and pop on the same FIFO both take effect when each is permitted (count unchanged); a pointer at DEPTH-1 SHALL wrap to 0.
REQ-017 SHALL keep a drop flag set if a new drop and a status read of that flag occur on the same edge.

Reset
REQ-018 SHALL, while reset=0, asynchronously clear both FIFOs (pointers and counts to 0), d_out=0, in_drop=0, out_drop=0; SHALL force net_ri=0, net_so=0, net_do=0.
REQ-019 SHALL discard all buffered flits on reset mid-operation; net_ri SHALL rise in the first cycle after reset deasserts.

Verification (DATA_W=64, DEPTH=4)
REQ-020 Reset then idle -> d_out=0, net_so=0, net_ri=1; status read at 01 and 11 -> d_out=0.
REQ-021 Write 5 flits to addr 10 with net_ro=0 -> first 4 stored; read 11 -> d_out=0x13 (full, drop, count 4); second read 11 -> 0x11.
REQ-022 Head VC bit=1, net_ro=1, net_polarity toggling each cycle -> net_so only in polarity=1 cycles; flits leave in FIFO order; count decrements by 1 per send.
REQ-023 Push 4 flits via net_si -> net_ri=0; 5th net_si dropped; read 01 -> 0x13; read 00 four times -> flits in order, each one cycle after its read; 5th read 00 -> 0.
REQ-024 Input FIFO at 2 entries; net_si push and addr-00 pop on the same edge -> count stays 2; head advances; order preserved across pointer wrap.
REQ-025 Reset asserted mid-stream with 3 flits in each FIFO -> net_so, net_ri, d_out go 0 immediately; after release both status reads -> 0.
